activity_sequencer: RTL and testbench

- Parametrised, N-channel successor to the switch-driven activity trigger used with the TDC sensor.
- Drives `trig` lines into an array of RISCVActivity instances, with a programmable active-channel count and four activity modes (continuous, timed burst, PRBS, ramp).
- Provides a `sync_mark` pulse to align the ILA/TDC capture with activity onset, plus `busy`/`done` status.
- Sits between the debounced button/switch inputs and the activity generators, in the clkActivity domain.

---
 rtl/act_seq_pkg.sv | 20 ++
 rtl/act_lfsr16.sv | 18 +
 rtl/activity_sequencer.sv | 124 ++++++++++++
 tb/tb_activity_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/act_seq_pkg.sv
// act_seq_pkg: shared types, LFSR constants and mask/popcount helpers for activity_sequencer.
package act_seq_pkg;

    typedef enum logic [1:0] {MODE_TOGGLE, MODE_BURST, MODE_PRBS, MODE_RAMP} mode_t;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5 into bit 15.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [63:0] therm_mask(input logic [6:0] n);
        return (n >= 7'd64) ? '1 : (64'd1 << n) - 64'd1;
    endfunction

    function automatic logic [6:0] popcount(input logic [63:0] v);
        popcount = '0;
        for (int i = 0; i < 64; i++) popcount += 7'(v[i]);
    endfunction

endpackage

// File: rtl/act_lfsr16.sv
// act_lfsr16: 16-bit Fibonacci LFSR with synchronous reload to a seed.
module act_lfsr16
    import act_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        reload,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    always_ff @(posedge clk) begin
        if (!rst_n || reload) value <= seed;
        else if (en) value <= {^(value & LFSR_TAPS), value[15:1]};
    end

endmodule

// File: rtl/activity_sequencer.sv
// activity_sequencer: N-channel trig sequencer (toggle/burst/PRBS/ramp) with sync_mark/busy/done.
// Define ACT_SEQ_STAT_EN to add run_cycles/toggle_count statistics outputs.
module activity_sequencer
    import act_seq_pkg::*;
#(
    parameter int          N_CH      = 16,
    parameter int          LEVEL_W   = $clog2(N_CH + 1),
    parameter int          BURST_W   = 16,
    parameter logic [15:0] LFSR_SEED = DEFAULT_SEED
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         mode,
    input  logic [LEVEL_W-1:0] level,
    input  logic [BURST_W-1:0] burst_len,
    output logic [N_CH-1:0]    trig,
    output logic               sync_mark,
    output logic               busy,
    output logic               done
`ifdef ACT_SEQ_STAT_EN
    ,
    output logic [31:0]        run_cycles,
    output logic [31:0]        toggle_count
`endif
);

    state_t             state;
    mode_t              mode_q;
    logic               start_q, rise, last_step, leave;
    logic [LEVEL_W-1:0] level_q, act, lvl_in;
    logic [BURST_W-1:0] len_q, cnt, len_in;
    logic [15:0]        lfsr;
    logic [N_CH-1:0]    mask, prbs_v, tv, trig_nx;

    act_lfsr16 u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (state == ST_RUN),
        .reload (state == ST_IDLE && rise),
        .seed   (LFSR_SEED),
        .value  (lfsr)
    );

    assign rise      = start & ~start_q;
    assign lvl_in    = (level > LEVEL_W'(N_CH)) ? LEVEL_W'(N_CH) : level;
    assign len_in    = (burst_len == '0) ? BURST_W'(1) : burst_len;
    assign last_step = cnt == BURST_W'(1);

    always_comb begin
        prbs_v = '0;
        for (int i = 0; i < N_CH; i++) prbs_v[i] = lfsr[i % 16];
        mask    = N_CH'(therm_mask(7'(mode_q == MODE_RAMP ? act : level_q)));
        tv      = (mode_q == MODE_PRBS) ? prbs_v : '1;
        trig_nx = (trig ^ (tv & mask)) & mask;
        leave   = abort | ((mode_q == MODE_BURST) ? last_step :
                           (mode_q == MODE_RAMP)  ? (level_q == '0 || (last_step && act >= level_q)) :
                           ~start);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            start_q   <= 1'b1;  // a start already high out of reset must not look like a rising edge
            mode_q    <= MODE_TOGGLE;
            level_q   <= '0;
            len_q     <= '0;
            cnt       <= '0;
            act       <= '0;
            trig      <= '0;
            sync_mark <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            start_q   <= start;
            sync_mark <= 1'b0;
            done      <= 1'b0;
            case (state)
                ST_IDLE: if (rise) begin
                    mode_q    <= mode_t'(mode);
                    level_q   <= lvl_in;
                    len_q     <= len_in;
                    cnt       <= len_in;
                    act       <= (lvl_in == '0) ? '0 : LEVEL_W'(1);
                    sync_mark <= 1'b1;
                    busy      <= 1'b1;
                    state     <= ST_RUN;
                end
                ST_RUN: begin
                    trig <= trig_nx;
                    if (leave) state <= ST_DRAIN;
                    else if (mode_q == MODE_RAMP && last_step) begin
                        act <= act + LEVEL_W'(1);
                        cnt <= len_q;
                    end else cnt <= cnt - BURST_W'(1);
                end
                ST_DRAIN: begin
                    trig  <= '0;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ACT_SEQ_STAT_EN
    logic [32:0] tc_sum;
    assign tc_sum = {1'b0, toggle_count} + 33'(popcount(64'(trig ^ trig_nx)));

    always_ff @(posedge clk) begin
        if (!rst_n || (state == ST_IDLE && rise)) begin
            run_cycles   <= '0;
            toggle_count <= '0;
        end else if (state == ST_RUN) begin
            if (run_cycles != '1) run_cycles <= run_cycles + 32'd1;
            toggle_count <= tc_sum[32] ? '1 : tc_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_activity_sequencer.sv
// tb_activity_sequencer: directed self-checking bench for activity_sequencer (N_CH=16).
module tb_activity_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start, abort;
    logic [1:0]  mode;
    logic [4:0]  level;
    logic [15:0] burst_len;
    logic [15:0] trig;
    logic        sync_mark, busy, done;
    int          checks = 0;
    int          errors = 0;
`ifdef ACT_SEQ_STAT_EN
    logic [31:0] run_cycles, toggle_count;
`endif

    activity_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .mode         (mode),
        .level        (level),
        .burst_len    (burst_len),
        .trig         (trig),
        .sync_mark    (sync_mark),
        .busy         (busy),
        .done         (done)
`ifdef ACT_SEQ_STAT_EN
        ,
        .run_cycles   (run_cycles),
        .toggle_count (toggle_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One idle edge with start low, then the launch edge k; samples taken just after k.
    task automatic go(input logic [1:0] m, input logic [4:0] l, input logic [15:0] b);
        start = 1'b0;
        tick();
        mode = m;
        level = l;
        burst_len = b;
        start = 1'b1;
        tick();
        check("launch_sync", sync_mark, 1);
        check("launch_busy", busy, 1);
        check("launch_trig", trig, 0);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic prbs_run(input string tag);
        logic [15:0] m, e;
        m = 16'hACE1;
        e = '0;
        go(2'd2, 5'd16, 16'd1);
        for (int j = 0; j < 100; j++) begin
            tick();
            e ^= m;
            m = {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
            check(tag, trig, e);
        end
        start = 1'b0;
        tick();
        tick();
        check({tag, "_done"}, done, 1);
        check({tag, "_trig0"}, trig, 0);
    endtask

    logic [3:0] ramp_exp [12] = '{4'h1, 4'h0, 4'h1, 4'h2, 4'h1, 4'h2, 4'h5, 4'h2, 4'h5, 4'hA, 4'h5, 4'hA};
    int n;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        mode = 2'd0;
        level = 5'd0;
        burst_len = 16'd0;
        tick();
        tick();
        check("rst_trig", trig, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sync", sync_mark, 0);
        rst_n = 1'b1;

        // TOGGLE level 3
        go(2'd0, 5'd3, 16'd0);
        for (int j = 1; j <= 9; j++) begin
            tick();
            check("tog_trig", trig, (j % 2) ? 16'h0007 : 16'h0000);
            check("tog_sync", sync_mark, 0);
        end
        start = 1'b0;
        tick();
        check("tog_exit_busy", busy, 1);
        check("tog_exit_done", done, 0);
        tick();
        check("tog_done", done, 1);
        check("tog_busy", busy, 0);
        check("tog_trig0", trig, 0);
        tick();
        check("tog_done_once", done, 0);

        // BURST level 16, length 5; start dropped mid-burst must not matter
        go(2'd1, 5'd16, 16'd5);
        for (int j = 1; j <= 5; j++) begin
            if (j == 2) start = 1'b0;
            tick();
            check("burst_trig", trig, (j % 2) ? 16'hFFFF : 16'h0000);
            check("burst_busy", busy, 1);
            check("burst_nodone", done, 0);
        end
        tick();
        check("burst_done", done, 1);
        check("burst_busy_end", busy, 0);
        check("burst_trig0", trig, 0);

        // RAMP level 4, 3 edges per step
        go(2'd3, 5'd4, 16'd3);
        start = 1'b0;
        for (int j = 0; j < 12; j++) begin
            tick();
            check("ramp_trig", trig, {12'h000, ramp_exp[j]});
            check("ramp_nodone", done, 0);
        end
        tick();
        check("ramp_done", done, 1);
        check("ramp_trig0", trig, 0);

        // PRBS twice: reseed gives the same sequence
        prbs_run("prbs1");
        prbs_run("prbs2");

        // level 20 saturates to 16: ramp of 16 single-edge steps
        go(2'd3, 5'd20, 16'd1);
        start = 1'b0;
        wait_done(n);
        check("sat_len", n, 17);

        // burst_len 0 behaves as 1
        go(2'd1, 5'd2, 16'd0);
        start = 1'b0;
        tick();
        check("len0_trig", trig, 16'h0003);
        check("len0_busy", busy, 1);
        tick();
        check("len0_done", done, 1);

        // abort during a long burst
        go(2'd1, 5'd2, 16'd100);
        tick();
        check("abort_trig1", trig, 16'h0003);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 1);
        check("abort_nodone", done, 0);
        tick();
        check("abort_done", done, 1);
        check("abort_trig0", trig, 0);

        // abort in IDLE is ignored
        abort = 1'b1;
        tick();
        tick();
        abort = 1'b0;
        check("idle_abort_busy", busy, 0);
        check("idle_abort_done", done, 0);

        // reset mid-run, then start still high gives no launch
        go(2'd0, 5'd4, 16'd0);
        tick();
        check("mid_trig", trig, 16'h000F);
        rst_n = 1'b0;
        tick();
        check("mid_rst_trig", trig, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            check("hold_busy", busy, 0);
            check("hold_sync", sync_mark, 0);
            check("hold_done", done, 0);
        end
        start = 1'b0;

`ifdef ACT_SEQ_STAT_EN
        go(2'd1, 5'd4, 16'd10);
        start = 1'b0;
        wait_done(n);
        check("stat_wait", n, 11);
        check("stat_run", run_cycles, 10);
        check("stat_tog", toggle_count, 40);
        tick();
        check("stat_run_hold", run_cycles, 10);
        check("stat_tog_hold", toggle_count, 40);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
